// File: rtl/execute_stage.sv
// Execute stage of the 32-bit integer core: operand forwarding, ALU,
// load-use bubble insertion and the registered EX/MEM bundle.
module execute_stage #(
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imm,
  input  logic [4:0]  ctl,
  input  logic        src_imm,
  input  logic        read_reg1,
  input  logic        read_reg2,
  input  logic [4:0]  reg1_addr,
  input  logic [4:0]  reg2_addr,
  input  logic [4:0]  write_reg,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_data,
  input  logic        stall_in,
  output logic        stall_out,
  output logic [31:0] ex_result,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_write_reg,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write
);

  logic [31:0] ex_result_q, ex_result_d;
  logic [31:0] ex_store_data_q, ex_store_data_d;
  logic [4:0]  ex_write_reg_q, ex_write_reg_d;
  logic        ex_reg_write_q, ex_reg_write_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic        ex_mem_write_q, ex_mem_write_d;

  logic        ex_fwd_ok, wb_fwd_ok;
  logic [31:0] op_a, op_b_reg, op_b, alu_res;
  logic        load_use;

  // A load result is not available in ex_result, so only non-load writers forward from EX.
  assign ex_fwd_ok = ENABLE_FWD && ex_reg_write_q && !ex_mem_read_q;
  assign wb_fwd_ok = ENABLE_FWD && wb_reg_write;

  function automatic logic [31:0] fwd(
    input logic [4:0]  idx,
    input logic [31:0] rf,
    input logic        ex_ok,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_val,
    input logic        wb_ok,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_val
  );
    if (idx == 5'd0)                  return 32'd0;
    else if (ex_ok && ex_rd == idx)   return ex_val;
    else if (wb_ok && wb_rd == idx)   return wb_val;
    else                              return rf;
  endfunction

  // Operand selection: x0 is hard zero, EX result beats WB data beats register file.
  always_comb begin
    op_a     = fwd(reg1_addr, rs1_data, ex_fwd_ok, ex_write_reg_q, ex_result_q,
                   wb_fwd_ok, wb_write_reg, wb_data);
    op_b_reg = fwd(reg2_addr, rs2_data, ex_fwd_ok, ex_write_reg_q, ex_result_q,
                   wb_fwd_ok, wb_write_reg, wb_data);
    op_b     = src_imm ? imm : op_b_reg;
  end

  // ALU; undefined op codes produce 0.
  always_comb begin
    alu_res = 32'd0;
    case (ctl)
      5'd0:  alu_res = op_a & op_b;
      5'd1:  alu_res = op_a | op_b;
      5'd2:  alu_res = op_a + op_b;
      5'd3:  alu_res = op_a ^ op_b;
      5'd4:  alu_res = op_a << op_b[4:0];
      5'd5:  alu_res = op_a >> op_b[4:0];
      5'd15: alu_res = $signed(op_a) >>> op_b[4:0];
      5'd6:  alu_res = op_a - op_b;
      5'd7:  alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      5'd13: alu_res = (op_a < op_b) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  // Load-use detection against the instruction currently held in EX.
  always_comb begin
    load_use  = ex_mem_read_q && (ex_write_reg_q != 5'd0) &&
                ((read_reg1 && reg1_addr == ex_write_reg_q) ||
                 (read_reg2 && reg2_addr == ex_write_reg_q));
    stall_out = !rst && (load_use || stall_in);
  end

  // Next EX/MEM bundle: hold on downstream stall, bubble on load-use, else load.
  always_comb begin
    ex_result_d     = ex_result_q;
    ex_store_data_d = ex_store_data_q;
    ex_write_reg_d  = ex_write_reg_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    if (stall_in) begin
      // hold everything; load_use is re-evaluated once stall_in drops
    end else if (load_use) begin
      ex_result_d     = 32'd0;
      ex_store_data_d = 32'd0;
      ex_write_reg_d  = 5'd0;
      ex_reg_write_d  = 1'b0;
      ex_mem_read_d   = 1'b0;
      ex_mem_write_d  = 1'b0;
    end else begin
      ex_result_d     = alu_res;
      ex_store_data_d = op_b_reg;
      ex_write_reg_d  = write_reg;
      ex_reg_write_d  = reg_write && (write_reg != 5'd0);
      ex_mem_read_d   = mem_read;
      ex_mem_write_d  = mem_write;
    end
  end

  // EX/MEM pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_result_q     <= 32'd0;
      ex_store_data_q <= 32'd0;
      ex_write_reg_q  <= 5'd0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
    end else begin
      ex_result_q     <= ex_result_d;
      ex_store_data_q <= ex_store_data_d;
      ex_write_reg_q  <= ex_write_reg_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
    end
  end

  assign ex_result     = ex_result_q;
  assign ex_store_data = ex_store_data_q;
  assign ex_write_reg  = ex_write_reg_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with an expected-output queue.
module tb_execute_stage;

  logic        clk, rst;
  logic [31:0] imm;
  logic [4:0]  ctl;
  logic        src_imm, read_reg1, read_reg2;
  logic [4:0]  reg1_addr, reg2_addr, write_reg;
  logic        reg_write, mem_read, mem_write;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic        stall_in, stall_out;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] sd;
    logic        chk_sd;
    logic [4:0]  wr;
    logic        rw, mr, mw;
  } exp_t;
  exp_t exp_q[$];

  execute_stage #(.ENABLE_FWD(1'b1)) dut (
    .clk(clk), .rst(rst), .imm(imm), .ctl(ctl), .src_imm(src_imm),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .write_reg(write_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
    .stall_in(stall_in), .stall_out(stall_out),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [4:0] c, input logic si, input logic [31:0] im,
                       input logic rr1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic rr2, input logic [4:0] a2, input logic [31:0] d2,
                       input logic [4:0] wr, input logic rw, input logic mr, input logic mw);
    ctl = c; src_imm = si; imm = im;
    read_reg1 = rr1; reg1_addr = a1; rs1_data = d1;
    read_reg2 = rr2; reg2_addr = a2; rs2_data = d2;
    write_reg = wr; reg_write = rw; mem_read = mr; mem_write = mw;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_reg_write = en; wb_write_reg = rd; wb_data = d;
  endtask

  task automatic push(input string tag, input logic [31:0] res, input logic [31:0] sd,
                      input logic chk_sd, input logic [4:0] wr,
                      input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.tag = tag; e.res = res; e.sd = sd; e.chk_sd = chk_sd;
    e.wr = wr; e.rw = rw; e.mr = mr; e.mw = mw;
    exp_q.push_back(e);
  endtask

  // Advance one edge and compare the registered bundle with the oldest expectation.
  task automatic tick_cmp();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_res"}, ex_result, e.res);
      if (e.chk_sd) chk({e.tag, "_sd"}, ex_store_data, e.sd);
      chk({e.tag, "_wr"}, {27'd0, ex_write_reg}, {27'd0, e.wr});
      chk({e.tag, "_rw"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk({e.tag, "_mr"}, {31'd0, ex_mem_read}, {31'd0, e.mr});
      chk({e.tag, "_mw"}, {31'd0, ex_mem_write}, {31'd0, e.mw});
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, stall_out}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b1;
    instr(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    // reset, with stall_in high to show stall_out stays low
    chk_stall("rst_stall_out", 1'b0);
    push("rst1", 0, 0, 1, 0, 0, 0, 0); tick_cmp();
    push("rst2", 0, 0, 1, 0, 0, 0, 0); tick_cmp();
    rst = 1'b0; stall_in = 1'b0;

    // addi x3 = x1 + 5
    instr(5'd2, 1, 32'd5, 1, 5'd1, 32'd10, 0, 5'd0, 32'd0, 5'd3, 1, 0, 0);
    chk_stall("addi_stall", 1'b0);
    push("addi", 32'd15, 0, 1, 5'd3, 1, 0, 0); tick_cmp();

    // ALU sweep, A = x1 = FFFF_FFF0, B = x2 = 4
    instr(5'd4, 0, 0, 1, 5'd1, 32'hFFFF_FFF0, 1, 5'd2, 32'd4, 5'd10, 1, 0, 0);
    push("sll", 32'hFFFF_FF00, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd5;  push("srl", 32'h0FFF_FFFF, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd15; push("sra", 32'hFFFF_FFFF, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd6;  push("sub", 32'hFFFF_FFEC, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd7;  push("slt", 32'd1, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd13; push("sltu", 32'd0, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd31; push("op31", 32'd0, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd0;  push("and", 32'd0, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd1;  push("or", 32'hFFFF_FFF4, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    ctl = 5'd3;  push("xor", 32'hFFFF_FFF4, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();
    // immediate B, store data still follows rs2
    ctl = 5'd2; src_imm = 1'b1; imm = 32'd1;
    push("addi_sd", 32'hFFFF_FFF1, 32'd4, 1, 5'd10, 1, 0, 0); tick_cmp();

    // EX forwarding beats WB forwarding
    instr(5'd2, 0, 0, 1, 5'd1, 32'd3, 1, 5'd2, 32'd4, 5'd5, 1, 0, 0);
    push("add_x5", 32'd7, 32'd4, 1, 5'd5, 1, 0, 0); tick_cmp();
    instr(5'd6, 0, 0, 1, 5'd5, 32'd99, 1, 5'd5, 32'd99, 5'd6, 1, 0, 0);
    wb(1, 5'd5, 32'd50);
    push("fwd_ex", 32'd0, 32'd7, 1, 5'd6, 1, 0, 0); tick_cmp();
    // WB forwarding on rs1, x0 on rs2 ignores rf data
    instr(5'd2, 0, 0, 1, 5'd5, 32'd99, 1, 5'd0, 32'd77, 5'd9, 1, 0, 0);
    push("fwd_wb", 32'd50, 32'd0, 1, 5'd9, 1, 0, 0); tick_cmp();
    wb(0, 0, 0);

    // load-use: lw x7, then add x8 = x7 + x1
    instr(5'd2, 1, 32'd8, 1, 5'd1, 32'h100, 0, 5'd0, 32'd0, 5'd7, 1, 1, 0);
    push("lw_x7", 32'h108, 32'd0, 1, 5'd7, 1, 1, 0); tick_cmp();
    instr(5'd2, 0, 0, 1, 5'd7, 32'd0, 1, 5'd1, 32'd1, 5'd8, 1, 0, 0);
    chk_stall("lu_stall_on", 1'b1);
    push("lu_bubble", 32'd0, 32'd0, 0, 5'd0, 0, 0, 0); tick_cmp();
    chk_stall("lu_stall_off", 1'b0);
    wb(1, 5'd7, 32'h1234);
    push("lu_reexec", 32'h1235, 32'd1, 1, 5'd8, 1, 0, 0); tick_cmp();
    wb(0, 0, 0);

    // x0 handling
    instr(5'd2, 1, 32'd7, 1, 5'd0, 32'h55, 0, 5'd0, 32'd0, 5'd0, 1, 0, 0);
    wb(1, 5'd0, 32'hDEAD);
    push("x0_write", 32'd7, 32'd0, 1, 5'd0, 0, 0, 0); tick_cmp();
    instr(5'd2, 0, 0, 1, 5'd0, 32'h11, 1, 5'd0, 32'h22, 5'd4, 1, 0, 0);
    push("x0_read", 32'd0, 32'd0, 1, 5'd4, 1, 0, 0); tick_cmp();
    wb(0, 0, 0);

    // stall_in hold during a store
    instr(5'd2, 1, 32'd4, 1, 5'd1, 32'h200, 1, 5'd2, 32'hCAFE, 5'd0, 0, 0, 1);
    push("sw", 32'h204, 32'hCAFE, 1, 5'd0, 0, 0, 1); tick_cmp();
    instr(5'd2, 1, 32'd1, 1, 5'd1, 32'h200, 0, 5'd0, 32'd0, 5'd11, 1, 0, 0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_stall("hold_stall", 1'b1);
      push("hold", 32'h204, 32'hCAFE, 1, 5'd0, 0, 0, 1); tick_cmp();
    end
    stall_in = 1'b0;
    chk_stall("rel_stall", 1'b0);
    push("after_rel", 32'h201, 32'd0, 1, 5'd11, 1, 0, 0); tick_cmp();

    // stall_in arriving during load-use holds the load, bubble after release
    instr(5'd2, 1, 32'd0, 1, 5'd1, 32'h200, 0, 5'd0, 32'd0, 5'd12, 1, 1, 0);
    push("lw_x12", 32'h200, 32'd0, 1, 5'd12, 1, 1, 0); tick_cmp();
    instr(5'd2, 0, 0, 1, 5'd12, 32'd0, 1, 5'd0, 32'd0, 5'd13, 1, 0, 0);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push("lu_held", 32'h200, 32'd0, 1, 5'd12, 1, 1, 0); tick_cmp();
    end
    stall_in = 1'b0;
    chk_stall("lu_after_hold", 1'b1);
    push("lu_bubble2", 32'd0, 32'd0, 0, 5'd0, 0, 0, 0); tick_cmp();
    wb(1, 5'd12, 32'h77);
    push("lu_reexec2", 32'h77, 32'd0, 1, 5'd13, 1, 0, 0); tick_cmp();
    wb(0, 0, 0);

    // reset in the middle of a stall
    instr(5'd2, 1, 32'd2, 1, 5'd1, 32'h200, 0, 5'd0, 32'd0, 5'd14, 1, 0, 0);
    push("addi_x14", 32'h202, 32'd0, 1, 5'd14, 1, 0, 0); tick_cmp();
    instr(5'd2, 1, 32'd9, 1, 5'd1, 32'h300, 0, 5'd0, 32'd0, 5'd15, 1, 0, 0);
    stall_in = 1'b1;
    push("pre_rst_hold", 32'h202, 32'd0, 1, 5'd14, 1, 0, 0); tick_cmp();
    rst = 1'b1;
    chk_stall("rst_mid_stall_out", 1'b0);
    push("rst_mid", 32'd0, 32'd0, 1, 5'd0, 0, 0, 0); tick_cmp();
    rst = 1'b0; stall_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
